// File: rtl/fwd_ctrl.sv
// Operand-forwarding and load-use hazard controller for the 16-bit, 8-register pipelined core.
// Tracks destinations in flight in EX/MEM/WB and drives the ID-stage operand select muxes.
module fwd_ctrl #(
   parameter int rfWidth           = 3,
   parameter int opForwardSelWidth = 2,
   parameter int DATA_WIDTH        = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         idValid,
   input  logic [rfWidth-1:0]           idSrcA,
   input  logic [rfWidth-1:0]           idSrcB,
   input  logic                         idUseA,
   input  logic                         idUseB,
   input  logic                         idWrEn,
   input  logic [rfWidth-1:0]           idDest,
   input  logic                         idMemRead,
   input  logic                         flush,
   output logic [opForwardSelWidth-1:0] selOpA,
   output logic [opForwardSelWidth-1:0] selOpB,
   output logic                         stall,
   output logic [DATA_WIDTH-1:0]        stallCnt
);

   typedef struct packed {
      logic               valid;
      logic               wrEn;
      logic [rfWidth-1:0] dest;
      logic               isLoad;
   } ex_slot_t;

   // Load-ness only matters in EX; MEM and WB can forward load data directly.
   typedef struct packed {
      logic               valid;
      logic               wrEn;
      logic [rfWidth-1:0] dest;
   } fwd_slot_t;

   localparam logic [opForwardSelWidth-1:0] SEL_ID  = opForwardSelWidth'(0);
   localparam logic [opForwardSelWidth-1:0] SEL_EX  = opForwardSelWidth'(1);
   localparam logic [opForwardSelWidth-1:0] SEL_MEM = opForwardSelWidth'(2);
   localparam logic [opForwardSelWidth-1:0] SEL_WB  = opForwardSelWidth'(3);

   ex_slot_t              ex_q, ex_d;
   fwd_slot_t             mem_q, wb_q;
   logic [DATA_WIDTH-1:0] cnt_q, cnt_d;

   logic hit_a_ex, hit_a_mem, hit_a_wb;
   logic hit_b_ex, hit_b_mem, hit_b_wb;
   logic raw_stall;

   // Register 0 is hardwired zero, so it never produces a hit.
   function automatic logic slot_hit(input logic valid, input logic wr_en,
                                     input logic [rfWidth-1:0] dest,
                                     input logic [rfWidth-1:0] src);
      return valid && wr_en && (dest != '0) && (dest == src);
   endfunction

   function automatic logic [opForwardSelWidth-1:0] pick_sel(input logic use_src, input logic h_ex,
                                                             input logic h_mem, input logic h_wb);
      logic [opForwardSelWidth-1:0] sel;
      sel = SEL_ID;
      if (!use_src)   sel = SEL_ID;
      else if (h_ex)  sel = SEL_EX;
      else if (h_mem) sel = SEL_MEM;
      else if (h_wb)  sel = SEL_WB;
      else            sel = SEL_ID;
      return sel;
   endfunction

   always_comb begin
      hit_a_ex  = slot_hit(ex_q.valid,  ex_q.wrEn,  ex_q.dest,  idSrcA);
      hit_a_mem = slot_hit(mem_q.valid, mem_q.wrEn, mem_q.dest, idSrcA);
      hit_a_wb  = slot_hit(wb_q.valid,  wb_q.wrEn,  wb_q.dest,  idSrcA);
      hit_b_ex  = slot_hit(ex_q.valid,  ex_q.wrEn,  ex_q.dest,  idSrcB);
      hit_b_mem = slot_hit(mem_q.valid, mem_q.wrEn, mem_q.dest, idSrcB);
      hit_b_wb  = slot_hit(wb_q.valid,  wb_q.wrEn,  wb_q.dest,  idSrcB);

      selOpA = pick_sel(idUseA, hit_a_ex, hit_a_mem, hit_a_wb);
      selOpB = pick_sel(idUseB, hit_b_ex, hit_b_mem, hit_b_wb);

      raw_stall = idValid && ((idUseA && hit_a_ex) || (idUseB && hit_b_ex)) && ex_q.isLoad;
      stall     = raw_stall && !flush;

      // A stalled or flushed ID instruction enters EX as a bubble.
      ex_d = '0;
      if (!stall && !flush) begin
         ex_d = '{valid: idValid, wrEn: idWrEn, dest: idDest, isLoad: idMemRead};
      end else begin
         ex_d = '0;
      end

      cnt_d = cnt_q;
      if (stall && (cnt_q != '1)) begin
         cnt_d = cnt_q + DATA_WIDTH'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
         cnt_q <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= '{valid: ex_q.valid, wrEn: ex_q.wrEn, dest: ex_q.dest};
         wb_q  <= mem_q;
         cnt_q <= cnt_d;
      end
   end

   assign stallCnt = cnt_q;

endmodule

// File: tb/tb_fwd_ctrl.sv
// Scoreboard bench for fwd_ctrl: stimulus pushes hand-computed expectations, a monitor
// pops and compares one entry per cycle on the falling clock edge.
module tb_fwd_ctrl;

   logic       clk;
   logic       rst;
   logic       idValid;
   logic [2:0] idSrcA, idSrcB, idDest;
   logic       idUseA, idUseB, idWrEn, idMemRead, flush;
   logic [1:0] selOpA, selOpB;
   logic       stall;
   logic [1:0] stallCnt;

   typedef struct {
      string      name;
      logic [1:0] sa;
      logic [1:0] sb;
      logic       st;
      logic [1:0] cnt;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   bit   done   = 1'b0;

   fwd_ctrl #(.rfWidth(3), .opForwardSelWidth(2), .DATA_WIDTH(2)) dut (
      .clk(clk), .rst(rst), .idValid(idValid), .idSrcA(idSrcA), .idSrcB(idSrcB),
      .idUseA(idUseA), .idUseB(idUseB), .idWrEn(idWrEn), .idDest(idDest),
      .idMemRead(idMemRead), .flush(flush), .selOpA(selOpA), .selOpB(selOpB),
      .stall(stall), .stallCnt(stallCnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic v, input logic [2:0] sa, input logic ua, input logic [2:0] sb,
                        input logic ub, input logic we, input logic [2:0] d, input logic mr,
                        input logic fl);
      idValid = v; idSrcA = sa; idUseA = ua; idSrcB = sb; idUseB = ub;
      idWrEn = we; idDest = d; idMemRead = mr; flush = fl;
   endtask

   task automatic push(input logic [1:0] ea, input logic [1:0] eb, input logic es,
                       input logic [1:0] ec, input string nm);
      exp_t e;
      e.name = nm; e.sa = ea; e.sb = eb; e.st = es; e.cnt = ec;
      q.push_back(e);
   endtask

   task automatic cyc(input logic v, input logic [2:0] sa, input logic ua, input logic [2:0] sb,
                      input logic ub, input logic we, input logic [2:0] d, input logic mr,
                      input logic fl, input logic [1:0] ea, input logic [1:0] eb,
                      input logic es, input logic [1:0] ec, input string nm);
      @(posedge clk);
      #1;
      drive(v, sa, ua, sb, ub, we, d, mr, fl);
      push(ea, eb, es, ec, nm);
   endtask

   // Monitor: the DUT presents a result every cycle, sampled on the falling edge.
   initial begin
      int cycles;
      exp_t e;
      cycles = 0;
      forever begin
         @(negedge clk);
         cycles++;
         if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (selOpA !== e.sa || selOpB !== e.sb || stall !== e.st || stallCnt !== e.cnt) begin
               errors++;
               $display("FAIL %s: got selOpA=%0d selOpB=%0d stall=%0d stallCnt=%0d, expected %0d %0d %0d %0d",
                        e.name, selOpA, selOpB, stall, stallCnt, e.sa, e.sb, e.st, e.cnt);
            end
         end else if (done) begin
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
         end
         if (cycles > 500) begin
            errors++;
            $display("FAIL timeout: %0d entries pending after %0d cycles, expected 0", q.size(), cycles);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
         end
      end
   end

   initial begin
      rst = 1'b1;
      drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
      cyc(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, "reset");
      @(negedge clk);
      #1 rst = 1'b0;

      // EX -> MEM -> WB -> none for a single ADD R3 producer
      cyc(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, "add_r3");
      cyc(1'b1, 3'd3, 1'b1, 3'd3, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd1, 2'd0, 1'b0, 2'd0, "fwd_ex");
      cyc(1'b1, 3'd3, 1'b1, 3'd3, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd2, 2'd0, 1'b0, 2'd0, "fwd_mem");
      cyc(1'b1, 3'd3, 1'b1, 3'd3, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd3, 2'd0, 1'b0, 2'd0, "fwd_wb");
      cyc(1'b1, 3'd3, 1'b1, 3'd3, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, "fwd_none");

      // Priority: R5 written by three consecutive instructions
      cyc(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, "wr_r5_a");
      cyc(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, "wr_r5_b");
      cyc(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, "wr_r5_c");
      cyc(1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 2'd1, 1'b0, 2'd0, "prio_ex");
      cyc(1'b1, 3'd5, 1'b1, 3'd5, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 2'd2, 2'd2, 1'b0, 2'd0, "prio_mem");

      // Load-use stall and its resolution
      cyc(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, "lw_r2");
      cyc(1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd1, 2'd0, 1'b1, 2'd0, "load_use_stall");
      cyc(1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd2, 2'd0, 1'b0, 2'd1, "load_use_after");
      cyc(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 2'd1, "lw_r2_b");
      cyc(1'b1, 3'd2, 1'b0, 3'd2, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd1, "no_use_no_stall");
      cyc(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 2'd1, "lw_r0");
      cyc(1'b1, 3'd0, 1'b1, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd1, "r0_no_stall");

      // Flush beats stall; flushed instruction (dest R6) leaves a bubble in EX
      cyc(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 2'd1, "lw_r4");
      cyc(1'b1, 3'd4, 1'b1, 3'd0, 1'b0, 1'b1, 3'd6, 1'b0, 1'b1, 2'd1, 2'd0, 1'b0, 2'd1, "flush_wins");
      cyc(1'b1, 3'd6, 1'b1, 3'd4, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 2'd2, 1'b0, 2'd1, "flush_bubble");

      // Back-to-back loads to R1: younger load in EX stalls
      cyc(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 2'd1, "lw_r1_a");
      cyc(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 2'd1, "lw_r1_b");
      cyc(1'b1, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 2'd1, 1'b1, 2'd1, "b2b_load_stall");
      cyc(1'b1, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 2'd2, 1'b0, 2'd2, "b2b_after");

      // Two more stalls drive the 2-bit counter to saturation
      cyc(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd7, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 2'd2, "lw_r7_a");
      cyc(1'b1, 3'd7, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd1, 2'd0, 1'b1, 2'd2, "stall_3");
      cyc(1'b1, 3'd7, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd2, 2'd0, 1'b0, 2'd3, "cnt_3");
      cyc(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd7, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 2'd3, "lw_r7_b");
      cyc(1'b1, 3'd7, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd1, 2'd0, 1'b1, 2'd3, "stall_4");
      cyc(1'b1, 3'd7, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd2, 2'd0, 1'b0, 2'd3, "cnt_saturate");

      // Asynchronous reset while a load-use hazard is pending
      cyc(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 2'd3, "lw_r3");
      @(posedge clk);
      #1;
      drive(1'b1, 3'd3, 1'b1, 3'd3, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
      #1 rst = 1'b1;
      push(2'd0, 2'd0, 1'b0, 2'd0, "reset_async");
      @(posedge clk);
      #1 rst = 1'b0;
      push(2'd0, 2'd0, 1'b0, 2'd0, "post_reset");
      cyc(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, "add_r5");
      cyc(1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 2'd1, 1'b0, 2'd0, "post_reset_fwd");

      @(posedge clk);
      #1;
      drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
      done = 1'b1;
   end

endmodule

// File: doc/fwd_ctrl.md
# fwd_ctrl

Operand-forwarding and load-use hazard controller for the 16-bit, 8-register pipelined MIPS core. It tracks the destination register of every instruction in flight in EX, MEM and WB, and drives the select inputs of the two ID-stage operand multiplexers (A and B) with source encoding ID/EX/MEM/WB. It raises a one-cycle stall when an instruction in ID consumes the result of a load still in EX. It also keeps a saturating stall counter for performance monitoring.

## Interface
Parameters:
- rfWidth, 3, register-address width (8 registers).
- opForwardSelWidth, 2, width of each select output.
- DATA_WIDTH, 16, width of the stall counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- idValid  in  1  ID stage holds a real instruction.
- idSrcA, idSrcB  in  rfWidth  source register addresses of the ID instruction.
- idUseA, idUseB  in  1  the ID instruction actually reads srcA / srcB.
- idWrEn  in  1  the ID instruction writes the register file.
- idDest  in  rfWidth  destination register of the ID instruction.
- idMemRead  in  1  the ID instruction is a load.
- flush  in  1  squash the ID instruction (branch taken).
- selOpA, selOpB  out  opForwardSelWidth  operand select: 0 = ID, 1 = EX, 2 = MEM, 3 = WB.
- stall  out  1  hold PC and IF/ID; insert a bubble into EX.
- stallCnt  out  DATA_WIDTH  number of stall cycles asserted since reset; saturates at all-ones.

## Operation
- **Tracking slots.** Three slots, EX, MEM and WB. Each slot holds {valid, wrEn, dest, isLoad}.
- **Slot advance.** On every rising clock edge, WB <= MEM and MEM <= EX.
- **EX slot load.**
  - EX <= {idValid, idWrEn, idDest, idMemRead} when neither stall nor flush is active.
  - Otherwise EX <= bubble (valid = 0).
- **Slot hit.** A slot "hits" source s when: valid && wrEn && dest != 0 && dest == s. Register 0 is hardwired zero and is never forwarded.
- **Select A.**
  - If idUseA = 0: selOpA = 0.
  - Otherwise priority is youngest first: EX hit -> 1, else MEM hit -> 2, else WB hit -> 3, else 0.
- **Select B.** Identical logic, using srcB / useB.
- **Load forwarding.** Forwarding from MEM or WB is permitted for loads, because dataMEM carries load data.
- **Raw stall.** rawStall = idValid && (EX hit on srcA with idUseA, or EX hit on srcB with idUseB) && EX.isLoad.
- **Stall output.** stall = rawStall && !flush. Select outputs are still computed normally during a stall.
- **Stall counter.** stallCnt increments by 1 on each clock edge where stall = 1, and holds at 2^DATA_WIDTH-1.
- **Flush.** A flush cancels the ID instruction only. Instructions already in EX, MEM and WB continue and still forward.

## Timing
- selOpA, selOpB and stall are combinational from the current ID inputs and the registered slots; they are valid in the same cycle.
- After reset: all slots invalid, selOpA = selOpB = 0, stall = 0, stallCnt = 0. These values apply immediately on rst assertion (asynchronous).
- **Load-use stall.** Lasts exactly one cycle: on the next edge the load moves to MEM. The held ID instruction then sees a MEM hit and selects 2.
- A load with dest 0 never stalls.
- Stall and flush in the same cycle: flush wins. stall = 0, a bubble is inserted, and the counter does not increment.
- Back-to-back loads to the same register: EX holds the younger load, so EX priority applies and a stall is raised.
- Reset asserted mid-stream: all slots are cleared asynchronously. The first post-reset instruction forwards from nothing.

## Test plan
- **Reset.** Assert rst mid-cycle with slots populated -> selOpA = selOpB = 0, stall = 0, stallCnt = 0 immediately.
- **EX/MEM/WB forwarding.**
  - Issue ADD R3 (wrEn, dest = 3), then an instruction reading srcA = 3 -> selOpA = 1.
  - Same consumer one cycle later -> selOpA = 2.
  - Same consumer two cycles later -> selOpA = 3.
  - Same consumer three cycles later -> selOpA = 0.
- **Priority.** Writes to R5 in WB, MEM and EX simultaneously; ID reads srcB = 5 -> selOpB = 1. With the EX write removed -> selOpB = 2.
- **Load-use.**
  - LW R2 in EX, ID reads R2 on A -> stall = 1 for exactly one cycle, stallCnt becomes 1.
  - Next cycle: stall = 0 and selOpA = 2.
  - Same case with idUseA = 0 -> no stall.
  - LW to R0 -> no stall, sel = 0.
- **Flush.** Load-use condition present with flush = 1 -> stall = 0, stallCnt unchanged. On the next cycle EX is a bubble: an ID read of that instruction's dest gives sel = 0 from EX.
- **Counter saturation.** DATA_WIDTH = 2, force four load-use stalls -> stallCnt reads 1, 2, 3, 3.
